// File: rtl/nios_debug_pkg.sv
// rtl/nios_debug_pkg.sv - shared defaults and IR codes for the Nios II debug command path
package nios_debug_pkg;

  localparam int DATA_W_DEF = 38;
  localparam int IR_W_DEF   = 2;
  localparam int ACTION_BIT = DATA_W_DEF - 1;

  typedef enum logic [1:0] {
    IR_OCIMEM    = 2'd0,
    IR_TRACEMEM  = 2'd1,
    IR_BREAK     = 2'd2,
    IR_TRACECTRL = 2'd3
  } ir_code_e;

endpackage

// File: rtl/nios_debug_tgl_sync.sv
// rtl/nios_debug_tgl_sync.sv - toggle synchroniser with history flop and post-reset blanking
module nios_debug_tgl_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tgl,
  output logic evt
);

  localparam int BW = $clog2(SYNC_STAGES + 2);

  logic [SYNC_STAGES-1:0] s;
  logic                   p;
  logic [BW-1:0]          blank_cnt;

  // p tracks the last stage even while blanking, so a toggle already high at reset is absorbed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s         <= '0;
      p         <= 1'b0;
      blank_cnt <= BW'(SYNC_STAGES + 1);
    end else begin
      s <= {s[SYNC_STAGES-2:0], tgl};
      p <= s[SYNC_STAGES-1];
      if (blank_cnt != '0)
        blank_cnt <= blank_cnt - BW'(1);
    end
  end

  assign evt = (s[SYNC_STAGES-1] ^ p) && (blank_cnt == '0);

endmodule

// File: rtl/nios_debug_cmd_queue.sv
// rtl/nios_debug_cmd_queue.sv - clk-side command queue fed by synchronised Update-IR/Update-DR toggles
module nios_debug_cmd_queue
  import nios_debug_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int IR_W        = IR_W_DEF,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       vs_uir_tgl,
  input  logic                       vs_udr_tgl,
  input  logic [IR_W-1:0]            ir_in,
  input  logic [DATA_W-1:0]          sr,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [IR_W-1:0]            cmd_ir,
  output logic [DATA_W-1:0]          cmd_data,
  output logic                       cmd_action,
  output logic                       uir_pulse,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       overflow,
  input  logic                       overflow_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic              uir_evt, udr_evt;
  logic [IR_W-1:0]   ir_reg, push_ir;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  count;
  logic              full, pop, push, drop;
  logic [IR_W+DATA_W-1:0] mem [DEPTH];

  nios_debug_tgl_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk(clk), .reset(reset), .tgl(vs_uir_tgl), .evt(uir_evt)
  );

  nios_debug_tgl_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk(clk), .reset(reset), .tgl(vs_udr_tgl), .evt(udr_evt)
  );

  // A coincident Update-IR must tag this push with the new IR, not the stale one
  assign push_ir = uir_evt ? ir_in : ir_reg;
  assign full    = (count == LVL_W'(DEPTH));
  assign pop     = (count != '0) && cmd_ready;
  assign push    = udr_evt && (!full || pop);
  assign drop    = udr_evt && full && !pop;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {push_ir, sr};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_reg    <= '0;
      uir_pulse <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      uir_pulse <= uir_evt;
      if (uir_evt)
        ir_reg <= ir_in;
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
      overflow <= drop | (overflow & ~overflow_clr);
    end
  end

  // Storage is not reset, so the head is masked to keep outputs at zero while empty
  assign cmd_valid          = (count != '0);
  assign {cmd_ir, cmd_data} = cmd_valid ? mem[rd_ptr] : '0;
  assign cmd_action         = cmd_data[DATA_W-1];
  assign fifo_level         = count;

endmodule

// File: tb/tb_nios_debug_cmd_queue.sv
// tb/tb_nios_debug_cmd_queue.sv - directed self-checking bench for nios_debug_cmd_queue
module tb_nios_debug_cmd_queue;
  import nios_debug_pkg::*;

  localparam int DATA_W = 38;
  localparam int IR_W   = 2;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              vs_uir_tgl, vs_udr_tgl;
  logic [IR_W-1:0]   ir_in;
  logic [DATA_W-1:0] sr;
  logic              cmd_valid, cmd_ready;
  logic [IR_W-1:0]   cmd_ir;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_action, uir_pulse, overflow, overflow_clr;
  logic [2:0]        fifo_level;

  int n_checks = 0;
  int n_pass   = 0;

  nios_debug_cmd_queue #(.DATA_W(DATA_W), .IR_W(IR_W), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .vs_uir_tgl(vs_uir_tgl), .vs_udr_tgl(vs_udr_tgl),
    .ir_in(ir_in), .sr(sr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .cmd_action(cmd_action),
    .uir_pulse(uir_pulse), .fifo_level(fifo_level), .overflow(overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Flip the UDR toggle and wait until the resulting push has been registered
  task automatic udr_event(input logic [DATA_W-1:0] d);
    sr = d;
    vs_udr_tgl = ~vs_udr_tgl;
    tick(3);
  endtask

  task automatic drain(input string tag, input logic [DATA_W-1:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, 64'(cmd_data), 64'(start + DATA_W'(i)));
      cmd_ready = 1'b1;
      tick(1);
      cmd_ready = 1'b0;
    end
  endtask

  initial begin
    int seen;
    reset = 1'b1; vs_uir_tgl = 1'b0; vs_udr_tgl = 1'b1;
    ir_in = '0; sr = '0; cmd_ready = 1'b0; overflow_clr = 1'b0;
    tick(3);
    chk("rst_valid", 64'(cmd_valid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ovf",   64'(overflow), 64'd0);
    chk("rst_pulse", 64'(uir_pulse), 64'd0);
    chk("rst_data",  64'(cmd_data), 64'd0);
    chk("rst_ir",    64'(cmd_ir), 64'd0);

    // Held-high UDR toggle must not look like an event after release
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (cmd_valid) seen++;
    end
    chk("blank_no_valid", 64'(seen), 64'd0);
    chk("blank_level",    64'(fifo_level), 64'd0);

    // First command: IR BREAK then action data; latency is three edges from drive
    ir_in = IR_BREAK;
    vs_uir_tgl = ~vs_uir_tgl;
    seen = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (uir_pulse && seen == 0) seen = i;
    end
    chk("uir_latency", 64'(seen), 64'd3);
    chk("uir_pulse_low", 64'(uir_pulse), 64'd0);
    sr = 38'h20_0000_00AB;
    vs_udr_tgl = ~vs_udr_tgl;
    tick(2);
    chk("udr_not_yet", 64'(cmd_valid), 64'd0);
    tick(1);
    chk("udr_valid",  64'(cmd_valid), 64'd1);
    chk("udr_ir",     64'(cmd_ir), 64'd2);
    chk("udr_data",   64'(cmd_data), 64'h20_0000_00AB);
    chk("udr_action", 64'(cmd_action), 64'd1);
    chk("udr_level",  64'(fifo_level), 64'd1);
    drain("pop_first", 38'h20_0000_00AB, 1);
    chk("pop_empty", 64'(cmd_valid), 64'd0);
    cmd_ready = 1'b1;
    tick(2);
    cmd_ready = 1'b0;
    chk("ready_empty_level", 64'(fifo_level), 64'd0);

    // Five pushes into a four-deep queue: the fifth is dropped
    for (int i = 1; i <= 5; i++) udr_event(DATA_W'(i));
    chk("ovf_level", 64'(fifo_level), 64'd4);
    chk("ovf_flag",  64'(overflow), 64'd1);
    chk("ovf_action", 64'(cmd_action), 64'd0);
    drain("ovf_drain", 38'd1, 4);
    chk("ovf_drained", 64'(cmd_valid), 64'd0);
    chk("ovf_sticky",  64'(overflow), 64'd1);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    chk("ovf_cleared", 64'(overflow), 64'd0);

    // Full queue with a pop on the push edge: both happen, no overflow
    for (int i = 0; i < 4; i++) udr_event(DATA_W'('h11 + i));
    sr = 38'h15;
    vs_udr_tgl = ~vs_udr_tgl;
    tick(2);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    chk("pp_level", 64'(fifo_level), 64'd4);
    chk("pp_ovf",   64'(overflow), 64'd0);
    drain("pp_drain", 38'h12, 4);
    chk("pp_empty", 64'(fifo_level), 64'd0);

    // Overflow coincident with clear keeps the flag set
    for (int i = 0; i < 4; i++) udr_event(DATA_W'('h21 + i));
    sr = 38'h25;
    vs_udr_tgl = ~vs_udr_tgl;
    tick(2);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    chk("clr_race_ovf",   64'(overflow), 64'd1);
    chk("clr_race_level", 64'(fifo_level), 64'd4);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    chk("clr_later", 64'(overflow), 64'd0);

    // Asynchronous reset with three queued commands
    drain("pre_rst_pop", 38'h21, 1);
    chk("pre_rst_level", 64'(fifo_level), 64'd3);
    reset = 1'b1;
    #1;
    chk("async_valid", 64'(cmd_valid), 64'd0);
    chk("async_level", 64'(fifo_level), 64'd0);
    chk("async_data",  64'(cmd_data), 64'd0);
    tick(2);
    reset = 1'b0;
    tick(6);
    udr_event(38'h3F_0000_0001);
    chk("post_rst_level", 64'(fifo_level), 64'd1);
    chk("post_rst_data",  64'(cmd_data), 64'h3F_0000_0001);
    chk("post_rst_ir",    64'(cmd_ir), 64'd0);
    chk("post_rst_ovf",   64'(overflow), 64'd0);
    drain("post_rst_pop", 38'h3F_0000_0001, 1);

    // Coincident UIR and UDR: the push carries the new IR
    ir_in = IR_TRACECTRL;
    sr = 38'h5A;
    vs_uir_tgl = ~vs_uir_tgl;
    vs_udr_tgl = ~vs_udr_tgl;
    tick(3);
    chk("same_cycle_ir",    64'(cmd_ir), 64'd3);
    chk("same_cycle_data",  64'(cmd_data), 64'h5A);
    chk("same_cycle_pulse", 64'(uir_pulse), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
